// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic-computing stream decoder:
// the FSM state encoding and the default stream-length field width.
package sc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int LEN_W_DEF = 8;

endpackage

// File: rtl/sc_bit_accum.sv
// Loadable down-counter of remaining stream bits plus a ones accumulator.
// A load clears the ones count; en consumes one bit of z.
module sc_bit_accum
    import sc_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [LEN_W-1:0] len,
    input  logic             en,
    input  logic             z,
    output logic [LEN_W-1:0] ones_nxt,
    output logic             last
);

    logic [LEN_W-1:0] remaining;
    logic [LEN_W-1:0] ones;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remaining <= '0;
            ones      <= '0;
        end else if (load) begin
            remaining <= len;
            ones      <= '0;
        end else if (en) begin
            remaining <= remaining - LEN_W'(1);
            ones      <= ones_nxt;
        end
    end

    // Count including the bit presented this cycle, so the result can be
    // registered on the same edge that consumes the final bit.
    assign ones_nxt = ones + LEN_W'(z);
    assign last     = en && (remaining == LEN_W'(1));

endmodule

// File: rtl/sc_stream_decoder.sv
// Stochastic bitstream decoder: counts ones over len qualified bits and
// presents the result with a valid/ready handshake.
// Define SC_STREAM_DECODER_BIPOLAR_EN for a bipolar result (2*ones - len).
module sc_stream_decoder
    import sc_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             z,
    input  logic             z_vld,
    output logic             busy,
    output logic [LEN_W:0]   res,
    output logic             res_vld,
    input  logic             res_rdy
);

    state_t           state_q;
    state_t           state_d;
    logic             acc_load;
    logic             acc_en;
    logic             acc_last;
    logic [LEN_W-1:0] ones_nxt;
    logic             start_zero;

`ifdef SC_STREAM_DECODER_BIPOLAR_EN
    logic [LEN_W-1:0] len_q;

    function automatic logic [LEN_W:0] fmt_res(input logic [LEN_W-1:0] ones,
                                               input logic [LEN_W-1:0] n);
        return {ones, 1'b0} - {1'b0, n};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q <= '0;
        end else if (acc_load) begin
            len_q <= len;
        end
    end
`else
    function automatic logic [LEN_W:0] fmt_res(input logic [LEN_W-1:0] ones);
        return {1'b0, ones};
    endfunction
`endif

    sc_bit_accum #(
        .LEN_W (LEN_W)
    ) u_accum (
        .clk      (clk),
        .rst      (rst),
        .load     (acc_load),
        .len      (len),
        .en       (acc_en),
        .z        (z),
        .ones_nxt (ones_nxt),
        .last     (acc_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign start_zero = (state_q == ST_IDLE) && start && (len == '0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (len == '0) ? ST_DONE : ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (acc_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (res_rdy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q != ST_IDLE);
        res_vld  = (state_q == ST_DONE);
        acc_load = (state_q == ST_IDLE) && start && (len != '0);
        acc_en   = (state_q == ST_COUNT) && z_vld;
    end

    // Result is captured once on entry to DONE and held until the next stream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res <= '0;
        end else if (start_zero) begin
            res <= '0;
        end else if (acc_last) begin
`ifdef SC_STREAM_DECODER_BIPOLAR_EN
            res <= fmt_res(ones_nxt, len_q);
`else
            res <= fmt_res(ones_nxt);
`endif
        end
    end

endmodule

// File: tb/tb_sc_stream_decoder.sv
// Self-checking bench for sc_stream_decoder with an expected-result queue.
// Expectations follow SC_STREAM_DECODER_BIPOLAR_EN when it is defined.
module tb_sc_stream_decoder;

    localparam int LEN_W = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             z;
    logic             z_vld;
    logic             busy;
    logic [LEN_W:0]   res;
    logic             res_vld;
    logic             res_rdy;

    logic [LEN_W:0]   exp_q[$];
    int               n_vec;
    int               n_err;

    sc_stream_decoder #(.LEN_W(LEN_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .len     (len),
        .z       (z),
        .z_vld   (z_vld),
        .busy    (busy),
        .res     (res),
        .res_vld (res_vld),
        .res_rdy (res_rdy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [LEN_W:0] model_res(input int ones, input int n);
`ifdef SC_STREAM_DECODER_BIPOLAR_EN
        return (LEN_W+1)'(2 * ones - n);
`else
        return (LEN_W+1)'(ones);
`endif
    endfunction

    // Drives one stream; returns at the falling edge after the last consumed bit.
    task automatic drive_stream(input int n, input logic [255:0] bits,
                                input bit gapped, input bit hold_start);
        int ones;
        ones = 0;
        for (int i = 0; i < n; i++) ones += int'(bits[i]);
        @(negedge clk);
        start = 1'b1;
        len   = LEN_W'(n);
        exp_q.push_back(model_res(ones, n));
        @(negedge clk);
        start = hold_start;
        len   = LEN_W'(1);
        for (int i = 0; i < n; i++) begin
            z_vld = 1'b1;
            z     = bits[i];
            @(negedge clk);
            if (gapped && i != n - 1) begin
                z_vld = 1'b0;
                z     = 1'b1;
                @(negedge clk);
            end
        end
        z_vld = 1'b0;
        z     = 1'b0;
    endtask

    task automatic wait_vld(input int budget, output bit seen);
        int k;
        k = 0;
        while (!res_vld && k < budget) begin
            @(negedge clk);
            k++;
        end
        seen = res_vld;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; len = '0; z = 1'b0; z_vld = 1'b0; res_rdy = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_vec++;
        if (res_vld !== 1'b0) begin n_err++; $display("FAIL reset_vld got %b want 0", res_vld); end
        n_vec++;
        if (res !== '0) begin n_err++; $display("FAIL reset_res got %h want 0", res); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [255:0] bits;
        logic [LEN_W:0] e;
        bit seen;
        bits = '0;
        bits[0] = 1'b1; bits[2] = 1'b1; bits[3] = 1'b1; bits[6] = 1'b1;
        drive_stream(8, bits, 1'b0, 1'b0);
        n_vec++;
        if (res_vld !== 1'b1) begin n_err++; $display("FAIL basic_latency res_vld got %b want 1", res_vld); end
        n_vec++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy got %b want 1", busy); end
        wait_vld(20, seen);
        e = exp_q.pop_front();
        n_vec++;
        if (!seen || res !== e) begin n_err++; $display("FAIL basic_res got %h (vld %b) want %h", res, seen, e); end
        res_rdy = 1'b1;
        @(negedge clk);
        res_rdy = 1'b0;
        n_vec++;
        if (res_vld !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL basic_handshake vld %b busy %b want 0 0", res_vld, busy);
        end
    endtask

    task automatic test_gapped();
        logic [255:0] bits;
        logic [LEN_W:0] e;
        bit seen;
        bits = '1;
        drive_stream(4, bits, 1'b1, 1'b0);
        n_vec++;
        if (res_vld !== 1'b1) begin n_err++; $display("FAIL gapped_latency res_vld got %b want 1", res_vld); end
        wait_vld(20, seen);
        e = exp_q.pop_front();
        n_vec++;
        if (!seen || res !== e) begin n_err++; $display("FAIL gapped_res got %h (vld %b) want %h", res, seen, e); end
        res_rdy = 1'b1;
        @(negedge clk);
        res_rdy = 1'b0;
    endtask

    task automatic test_len_zero();
        logic [LEN_W:0] e;
        @(negedge clk);
        start = 1'b1;
        len   = '0;
        exp_q.push_back('0);
        @(negedge clk);
        start = 1'b0;
        e = exp_q.pop_front();
        n_vec++;
        if (res_vld !== 1'b1 || res !== e) begin
            n_err++; $display("FAIL len0_done vld %b res %h want 1 %h", res_vld, res, e);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_vec++;
            if (res_vld !== 1'b1 || res !== e) begin
                n_err++; $display("FAIL len0_hold cyc %0d vld %b res %h want 1 %h", i, res_vld, res, e);
            end
        end
        res_rdy = 1'b1;
        @(negedge clk);
        res_rdy = 1'b0;
        n_vec++;
        if (res_vld !== 1'b0) begin n_err++; $display("FAIL len0_release vld got %b want 0", res_vld); end
    endtask

    task automatic test_ignore_start();
        logic [255:0] bits;
        logic [LEN_W:0] e;
        bit seen;
        bits = '0;
        bits[0] = 1'b1; bits[1] = 1'b1; bits[3] = 1'b1;
        drive_stream(4, bits, 1'b0, 1'b1);
        wait_vld(20, seen);
        e = exp_q.pop_front();
        n_vec++;
        if (!seen || res !== e) begin n_err++; $display("FAIL ignore_res got %h (vld %b) want %h", res, seen, e); end
        @(negedge clk);
        n_vec++;
        if (res_vld !== 1'b1 || res !== e) begin
            n_err++; $display("FAIL ignore_hold vld %b res %h want 1 %h", res_vld, res, e);
        end
        res_rdy = 1'b1;
        @(negedge clk);
        res_rdy = 1'b0;
        start   = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || res_vld !== 1'b0) begin
            n_err++; $display("FAIL ignore_handshake busy %b vld %b want 0 0", busy, res_vld);
        end
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL ignore_restart busy got %b want 0", busy); end
    endtask

    task automatic test_mid_reset();
        logic [255:0] bits;
        logic [LEN_W:0] e;
        bit seen;
        @(negedge clk);
        start = 1'b1;
        len   = LEN_W'(8);
        @(negedge clk);
        start = 1'b0;
        z_vld = 1'b1;
        z     = 1'b1;
        repeat (3) @(negedge clk);
        z_vld = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if (busy !== 1'b0 || res_vld !== 1'b0 || res !== '0) begin
            n_err++; $display("FAIL async_reset busy %b vld %b res %h want 0 0 0", busy, res_vld, res);
        end
        @(negedge clk);
        rst   = 1'b0;
        z_vld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (res_vld !== 1'b0 || busy !== 1'b0) begin
                n_err++; $display("FAIL reset_no_pulse cyc %0d vld %b busy %b want 0 0", i, res_vld, busy);
            end
        end
        z_vld = 1'b0;
        bits = '1;
        drive_stream(2, bits, 1'b0, 1'b0);
        wait_vld(20, seen);
        e = exp_q.pop_front();
        n_vec++;
        if (!seen || res !== e) begin n_err++; $display("FAIL post_reset_res got %h (vld %b) want %h", res, seen, e); end
        res_rdy = 1'b1;
        @(negedge clk);
        res_rdy = 1'b0;
    endtask

    task automatic test_max_len();
        logic [255:0] bits;
        logic [LEN_W:0] e;
        bit seen;
        for (int p = 0; p < 2; p++) begin
            bits = (p == 0) ? '1 : '0;
            drive_stream(255, bits, 1'b0, 1'b0);
            n_vec++;
            if (res_vld !== 1'b1) begin n_err++; $display("FAIL max_latency pass %0d vld got %b want 1", p, res_vld); end
            wait_vld(20, seen);
            e = exp_q.pop_front();
            n_vec++;
            if (!seen || res !== e) begin
                n_err++; $display("FAIL max_res pass %0d got %h (vld %b) want %h", p, res, seen, e);
            end
            res_rdy = 1'b1;
            @(negedge clk);
            res_rdy = 1'b0;
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_basic();
        test_gapped();
        test_len_zero();
        test_ignore_start();
        test_mid_reset();
        test_max_len();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
